// File: rtl/addr_sweeper_pkg.sv
// Shared mode encodings and tick-interval helpers for the ROM address sweeper.
package addr_sweeper_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL      = 2'd0,
    MODE_AUTO_WRAP   = 2'd1,
    MODE_AUTO_BOUNCE = 2'd2,
    MODE_HOLD        = 2'd3
  } mode_e;

  function automatic int tick_cycles(input int clk_freq, input int step_ms);
    return (clk_freq / 1000) * step_ms;
  endfunction

  function automatic int tick_width(input int ticks);
    return $clog2(ticks);
  endfunction

endpackage

// File: rtl/sweep_tick_gen.sv
// Interval counter: counts 0..TICKS-1 while enabled and flags the terminal count.
module sweep_tick_gen
  import addr_sweeper_pkg::*;
#(
  parameter int TICKS = 5,
  parameter int CW    = tick_width(TICKS)
) (
  input  logic sclk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // A clear cycle restarts the interval, so it never produces a tick itself.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/addr_sweeper.sv
// Walks a ROM address range (manual step, auto wrap, auto bounce) and
// registers the ROM word for every visited address after the read latency.
module addr_sweeper
  import addr_sweeper_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int ADDR_MIN = 0,
  parameter int ADDR_MAX = 2**AW - 1,
  parameter int CLK_FREQ = 50_000_000,
  parameter int STEP_MS  = 500,
  parameter int ROM_LAT  = 1
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          step_fwd,
  input  logic          step_back,
  input  logic [1:0]    mode,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          wrapped
);

  localparam int TICKS = tick_cycles(CLK_FREQ, STEP_MS);
  localparam int CW    = tick_width(TICKS);
  localparam logic [AW-1:0] AMIN = AW'(ADDR_MIN);
  localparam logic [AW-1:0] AMAX = AW'(ADDR_MAX);

  mode_e          mode_i, mode_q;
  logic [AW-1:0]  addr_q, addr_d, nxt;
  logic           dir_q, dir_d, up_eff;   // 1 = counting up
  logic           wrap_q, wrap_d;
  logic           armed;                  // low until the first post-reset edge
  logic           move, upd, clr, tick, auto_m;
  logic [ROM_LAT:0] vld_pipe;
  logic [DW-1:0]  dout_q;
  logic           dv_q;

  assign mode_i = mode_e'(mode);
  assign auto_m = (mode_i == MODE_AUTO_WRAP) || (mode_i == MODE_AUTO_BOUNCE);
  assign clr    = !armed || (mode_i != mode_q);

  sweep_tick_gen #(.TICKS(TICKS), .CW(CW)) u_tick (
    .sclk (sclk),
    .rst  (rst),
    .en   (auto_m),
    .clr  (clr),
    .tick (tick)
  );

  // State register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      addr_q <= AMIN;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
      armed  <= 1'b0;
      mode_q <= MODE_MANUAL;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      armed  <= 1'b1;
      mode_q <= mode_i;
    end
  end

  // Next-state logic
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    move   = 1'b0;
    up_eff = dir_q;
    nxt    = addr_q;
    unique case (mode_i)
      MODE_MANUAL: begin
        if (step_fwd && !step_back) begin
          move   = 1'b1;
          wrap_d = (addr_q == AMAX);
          addr_d = (addr_q == AMAX) ? AMIN : addr_q + AW'(1);
        end else if (step_back && !step_fwd) begin
          move   = 1'b1;
          wrap_d = (addr_q == AMIN);
          addr_d = (addr_q == AMIN) ? AMAX : addr_q - AW'(1);
        end
      end
      MODE_AUTO_WRAP: begin
        if (tick) begin
          move   = 1'b1;
          wrap_d = (addr_q == AMAX);
          addr_d = (addr_q == AMAX) ? AMIN : addr_q + AW'(1);
        end
      end
      MODE_AUTO_BOUNCE: begin
        if (tick) begin
          // Sitting on an endpoint already facing outward (reached manually): turn without a pulse.
          if (dir_q && addr_q == AMAX)  up_eff = 1'b0;
          if (!dir_q && addr_q == AMIN) up_eff = 1'b1;
          nxt    = up_eff ? addr_q + AW'(1) : addr_q - AW'(1);
          move   = 1'b1;
          addr_d = nxt;
          if (nxt == AMAX) begin
            dir_d  = 1'b0;
            wrap_d = 1'b1;
          end else if (nxt == AMIN) begin
            dir_d  = 1'b1;
            wrap_d = 1'b1;
          end else begin
            dir_d  = up_eff;
          end
        end
      end
      default: ;
    endcase
    // The first post-reset edge issues the initial read of ADDR_MIN.
    upd = move || !armed;
  end

  // Read-latency pipe and output capture
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], upd};
      dv_q     <= vld_pipe[ROM_LAT];
      if (vld_pipe[ROM_LAT]) dout_q <= rom_q;
    end
  end

  // Outputs
  always_comb begin
    rom_addr   = addr_q;
    wrapped    = wrap_q;
    dout       = dout_q;
    dout_valid = dv_q;
  end

endmodule

// File: tb/tb_addr_sweeper.sv
// Drives two sweeper instances (full range / ROM_LAT 1, and range 2..5 / ROM_LAT 3)
// from shared stimulus and compares every cycle against a behavioural model.
module tb_addr_sweeper;

  logic       sclk = 1'b0;
  logic       rst;
  logic       step_fwd, step_back;
  logic [1:0] mode;

  logic [3:0] ra0, ra1;
  logic [7:0] rq0, rq1, do0, do1;
  logic       dv0, dv1, wr0, wr1;

  always #5 sclk = ~sclk;

  addr_sweeper #(.AW(4), .DW(8), .ADDR_MIN(0), .ADDR_MAX(15),
                 .CLK_FREQ(1000), .STEP_MS(5), .ROM_LAT(1)) u0 (
    .sclk(sclk), .rst(rst), .step_fwd(step_fwd), .step_back(step_back), .mode(mode),
    .rom_addr(ra0), .rom_q(rq0), .dout(do0), .dout_valid(dv0), .wrapped(wr0));

  addr_sweeper #(.AW(4), .DW(8), .ADDR_MIN(2), .ADDR_MAX(5),
                 .CLK_FREQ(1000), .STEP_MS(5), .ROM_LAT(3)) u1 (
    .sclk(sclk), .rst(rst), .step_fwd(step_fwd), .step_back(step_back), .mode(mode),
    .rom_addr(ra1), .rom_q(rq1), .dout(do1), .dout_valid(dv1), .wrapped(wr1));

  // Synchronous ROMs holding q = A0 + addr
  logic [7:0] rp0;
  logic [7:0] rp1 [3];
  always @(posedge sclk) begin
    rp0    <= 8'hA0 + 8'(ra0);
    rp1[0] <= 8'hA0 + 8'(ra1);
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign rq0 = rp0;
  assign rq1 = rp1[2];

  // Reference model
  localparam int TK = 5;
  int mn  [2] = '{0, 2};
  int mx  [2] = '{15, 5};
  int lat [2] = '{1, 3};

  int         m_addr [2];
  bit         m_up   [2];
  bit         m_wrap [2];
  bit         m_dv   [2];
  logic [7:0] m_dout [2];
  bit         sv     [2][64];
  logic [7:0] sd     [2][64];
  bit         m_armed;
  logic [1:0] m_prev;
  int         m_since;
  int         n;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = mn[i]; m_up[i] = 1'b1; m_wrap[i] = 1'b0;
      m_dv[i] = 1'b0; m_dout[i] = 8'h00;
      for (int k = 0; k < 64; k++) sv[i][k] = 1'b0;
    end
    m_armed = 1'b0; m_since = 0; m_prev = 2'd0;
  endtask

  task automatic model_step();
    bit clr, auto_m, tick, moved;
    int rng, off, dlt, per, p;
    clr    = !m_armed || (mode != m_prev);
    auto_m = (mode == 2'd1) || (mode == 2'd2);
    tick   = auto_m && !clr && ((m_since + 1) % TK == 0);
    m_since = clr ? 0 : m_since + 1;
    for (int i = 0; i < 2; i++) begin
      moved = 1'b0; m_wrap[i] = 1'b0;
      rng = mx[i] - mn[i] + 1;
      off = m_addr[i] - mn[i];
      if ((mode == 2'd0 && step_fwd != step_back) || (mode == 2'd1 && tick)) begin
        dlt = (mode == 2'd0 && step_back) ? -1 : 1;
        m_wrap[i] = (dlt == 1 && off == rng - 1) || (dlt == -1 && off == 0);
        off = (off + dlt + rng) % rng;
        moved = 1'b1;
      end else if (mode == 2'd2 && tick) begin
        // Bounce as a cyclic walk over phases 0..2(R-1)-1
        per = 2 * (rng - 1);
        p = m_up[i] ? off : per - off;
        p = (p + 1) % per;
        off = (p < rng - 1) ? p : per - p;
        m_wrap[i] = (p == 0) || (p == rng - 1);
        m_up[i] = (p < rng - 1);
        moved = 1'b1;
      end
      m_addr[i] = mn[i] + off;
      if (moved || !m_armed) begin
        sv[i][(n + lat[i] + 1) % 64] = 1'b1;
        sd[i][(n + lat[i] + 1) % 64] = 8'hA0 + 8'(m_addr[i]);
      end
    end
    m_armed = 1'b1;
    m_prev  = mode;
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, i, n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rom_addr",   0, 32'(ra0), 32'(m_addr[0]));
    chk("wrapped",    0, 32'(wr0), 32'(m_wrap[0]));
    chk("dout_valid", 0, 32'(dv0), 32'(m_dv[0]));
    chk("dout",       0, 32'(do0), 32'(m_dout[0]));
    chk("rom_addr",   1, 32'(ra1), 32'(m_addr[1]));
    chk("wrapped",    1, 32'(wr1), 32'(m_wrap[1]));
    chk("dout_valid", 1, 32'(dv1), 32'(m_dv[1]));
    chk("dout",       1, 32'(do1), 32'(m_dout[1]));
  endtask

  task automatic cyc();
    if (rst) model_reset(); else model_step();
    @(posedge sclk); #1;
    for (int i = 0; i < 2; i++) begin
      m_dv[i] = rst ? 1'b0 : sv[i][n % 64];
      if (m_dv[i]) m_dout[i] = sd[i][n % 64];
      sv[i][n % 64] = 1'b0;
    end
    n++;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) cyc();
  endtask

  task automatic pulse(input bit f, input bit b);
    step_fwd = f; step_back = b;
    cyc();
    step_fwd = 1'b0; step_back = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; step_fwd = 1'b0; step_back = 1'b0;
    n = 0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(5);

    // Manual forward sweep across the wrap point
    for (int k = 0; k < 17; k++) begin
      pulse(1'b1, 1'b0);
      idle(2);
    end
    // Back from the bottom, then a cancelling pair
    while (m_addr[0] != 0) begin pulse(1'b0, 1'b1); idle(1); end
    idle(4);
    pulse(1'b0, 1'b1);
    idle(2);
    pulse(1'b1, 1'b1);
    idle(5);

    // Four back-to-back forward steps
    for (int k = 0; k < 4; k++) pulse(1'b1, 1'b0);
    idle(6);

    // Random manual keys, including adjacent-cycle updates
    for (int k = 0; k < 60; k++) pulse($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    idle(5);

    // Auto bounce with key noise
    mode = 2'd2;
    for (int k = 0; k < 60; k++) pulse($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    // Hold ignores everything
    mode = 2'd3;
    for (int k = 0; k < 15; k++) pulse($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);

    // Auto wrap, then a short asynchronous reset mid-interval
    mode = 2'd1;
    idle(37);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    cyc();
    rst = 1'b0;
    idle(25);

    // Random mode changes and keys
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      pulse($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addr_sweeper.md
Name: addr_sweeper

Overview:
Parametrised address generator that walks a synchronous ROM address range and presents the ROM word for each visited address. It supports manual stepping in both directions from debounced key pulses, plus timed auto-sweep in wrap or bounce mode. The address range, data width, ROM read latency and step interval are all configurable. It sits between the key debouncer outputs and a single-port ROM IP, and drives LEDs or a downstream consumer.

Parameters:
AW, 4, address width in bits
DW, 8, ROM data width in bits
ADDR_MIN, 0, lowest visited address
ADDR_MAX, 2**AW-1, highest visited address; must satisfy ADDR_MIN < ADDR_MAX
CLK_FREQ, 50_000_000, sclk frequency in Hz
STEP_MS, 500, auto-step interval in ms; TICK_CYCLES = CLK_FREQ/1000*STEP_MS, which must be >= 2
ROM_LAT, 1, ROM read latency in sclk cycles, range 1..4

Ports:
sclk  input  1  system clock
rst  input  1  reset; asynchronous assertion, active-high
step_fwd  input  1  single-cycle pulse: advance by one in manual mode
step_back  input  1  single-cycle pulse: retreat by one in manual mode
mode  input  2  0 = MANUAL, 1 = AUTO_WRAP, 2 = AUTO_BOUNCE, 3 = HOLD
rom_addr  output  AW  address to the ROM
rom_q  input  DW  ROM read data, valid ROM_LAT cycles after rom_addr changes
dout  output  DW  registered ROM word for the current address
dout_valid  output  1  one-cycle pulse when dout updates
wrapped  output  1  one-cycle pulse on every wrap or bounce reversal

Behaviour:
- Reset values: rom_addr = ADDR_MIN, dout = 0, dout_valid = 0, wrapped = 0, direction = up, tick counter = 0.
- Initial read: on the first cycle after rst deasserts, the block issues an initial read of ADDR_MIN through the same latency pipe. dout_valid first pulses ROM_LAT+1 cycles after deassertion.
- Tick counter: counts 0..TICK_CYCLES-1 and only runs in the AUTO modes. A tick is generated on the terminal count. Any change of mode clears the counter, so the first auto step occurs TICK_CYCLES cycles after entering an AUTO mode.
- MANUAL mode:
  - step_fwd: rom_addr increments; at ADDR_MAX it goes to ADDR_MIN and wrapped pulses.
  - step_back: rom_addr decrements; at ADDR_MIN it goes to ADDR_MAX and wrapped pulses.
  - step_fwd and step_back in the same cycle: no move.
- AUTO_WRAP mode: each tick behaves as step_fwd. Key pulses are ignored.
- AUTO_BOUNCE mode:
  - Each tick moves one address in the current direction.
  - On reaching ADDR_MAX the direction flips to down; on reaching ADDR_MIN it flips to up. wrapped pulses in the same cycle that the endpoint is written to rom_addr.
  - Endpoints are visited once per reversal, never repeated.
  - The direction register is retained across mode changes and reset only by rst.
- HOLD mode: rom_addr is frozen; ticks and keys are ignored.
- Address update: takes effect on the clock edge after the triggering pulse or tick. Every update pushes a token into a ROM_LAT-deep valid shift register.
- Output capture: when the token exits the shift register, dout <= rom_q and dout_valid = 1 for one cycle. Latency from rom_addr change to dout_valid is ROM_LAT+1 cycles.
- Back-to-back updates: consecutive updates (manual pulses on adjacent cycles) each yield their own dout_valid, in order, because the pipe is fully pipelined.
- Reset mid-operation: all state returns to reset values immediately; in-flight tokens are discarded.
- Arithmetic: address arithmetic is AW bits with explicit endpoint compares and no reliance on natural overflow. Non-power-of-two ranges must work.

Decomposition:
- Package addr_sweeper_pkg: the mode encodings MODE_MANUAL, MODE_AUTO_WRAP, MODE_AUTO_BOUNCE and MODE_HOLD, plus a function computing TICK_CYCLES and its counter width via clog2.
- One sub-module, sweep_tick_gen: a parametrised interval counter with a clear input and a one-cycle tick output.
- The address FSM and the latency pipe stay in the top module.

Test Plan:
- Reset release, defaults (AW=4, ROM_LAT=1, ROM holds q = 8'hA0 + addr) -> dout_valid pulses 2 cycles after deassertion with dout = 8'hA0 and rom_addr = 0.
- MANUAL, 17 step_fwd pulses spaced 3 cycles apart -> rom_addr runs 1..15 then 0 then 1. wrapped pulses exactly once, on the 15->0 step. Each dout equals 8'hA0 + addr.
- MANUAL, step_back from 0, then step_fwd and step_back together -> rom_addr = 15 and wrapped pulses; the simultaneous pair leaves rom_addr at 15 with no dout_valid.
- AUTO_BOUNCE, CLK_FREQ=1000, STEP_MS=5 (TICK_CYCLES=5), ADDR_MIN=2, ADDR_MAX=5 -> sequence 3,4,5,4,3,2,3 at 5-cycle spacing. wrapped pulses on reaching 5 and on reaching 2. Key pulses have no effect.
- ROM_LAT=3, four step_fwd pulses on consecutive cycles -> four dout_valid pulses on consecutive cycles, starting 4 cycles after the first address change, with data in order.
- AUTO_WRAP running, rst asserted mid-interval for 1 cycle -> rom_addr = ADDR_MIN and dout_valid low in-reset. The next auto step occurs TICK_CYCLES cycles after release; no stale dout_valid appears.
